// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, prefetches {pc, inst} pairs
// into a small FIFO for decode, handles redirects and flags illegal fetches.
module ifetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          MEM_SIZE = 256,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   fault_pc_reg, fault_pc_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          deq;
  logic          enq;
  logic          fetch_go;
  logic          has_space;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_ADDR);
  endfunction

  assign mem_addr  = fetch_pc_reg;
  assign out_valid = (count_reg != '0) && !redirect_valid;
  assign out_inst  = inst_mem[head_reg];
  assign out_pc    = pc_mem[head_reg];
  assign fault     = (state_reg == FAULT);
  assign fault_pc  = fault_pc_reg;

  assign deq       = out_valid && out_ready;
  // A slot freed by a same-cycle dequeue counts as space, giving 1 inst/cycle.
  assign has_space = (count_reg < DEPTH_C) || deq;
  assign fetch_go  = (state_reg == RUN) && !stall && !redirect_valid && has_space;
  assign enq       = fetch_go && is_legal(fetch_pc_reg);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    fault_pc_next = fault_pc_reg;
    count_next    = count_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;

    if (redirect_valid) begin
      // Flush: an empty FIFO only needs head to catch up with tail.
      count_next    = '0;
      head_next     = tail_reg;
      fetch_pc_next = redirect_pc;
      if (is_legal(redirect_pc)) begin
        state_next = RUN;
      end else begin
        state_next    = FAULT;
        fault_pc_next = redirect_pc;
      end
    end else begin
      count_next = count_reg + (AW + 1)'(enq) - (AW + 1)'(deq);
      if (deq) begin
        head_next = head_reg + AW'(1);
      end
      if (enq) begin
        tail_next     = tail_reg + AW'(1);
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (fetch_go && !is_legal(fetch_pc_reg)) begin
        state_next    = FAULT;
        fault_pc_next = fetch_pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      fetch_pc_reg <= PC_RESET;
      fault_pc_reg <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      fault_pc_reg <= fault_pc_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  // Entries are reset so the head reads as zero straight out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_mem[gi]   <= '0;
        inst_mem[gi] <= '0;
      end else if (enq && (tail_reg == AW'(gi))) begin
        pc_mem[gi]   <= fetch_pc_reg;
        inst_mem[gi] <= mem_inst;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: stimulus pushes expected {pc, inst} pairs,
// a negedge monitor pops and compares every completed output handshake.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  ifetch_ctrl #(.PC_RESET(32'h0), .MEM_SIZE(256), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_inst(mem_inst),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a is {16'hC0DE, a[15:0]}.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign mem_inst = word_at(mem_addr);

  task automatic expect_out(input logic [31:0] pc);
    sb.push_back({pc, word_at(pc)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got pc=%h inst=%h, required no output", out_pc, out_inst);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({out_pc, out_inst} !== e) begin
          n_bad++;
          $display("FAIL out_pair: got pc=%h inst=%h, required pc=%h inst=%h",
                   out_pc, out_inst, e[63:32], e[31:0]);
        end else begin
          $display("ok   out_pair: pc=%h inst=%h", out_pc, out_inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc",    out_pc,   32'h0);
    check("rst_out_inst",  out_inst, 32'h0);
    check("rst_fault",     32'(fault), 32'h0);
    check("rst_fault_pc",  fault_pc, 32'h0);
    check("rst_mem_addr",  mem_addr, 32'h0);
    #10;

    // Streaming with out_ready high: exactly four fetch cycles.
    expect_out(32'h0); expect_out(32'h4); expect_out(32'h8); expect_out(32'hC);
    rst_n = 1'b1; out_ready = 1'b1; stall = 1'b0;
    #1;
    check("p1_valid_before_edge", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (i == 0) check("p1_valid_cycle2", 32'(out_valid), 32'h1);
    end
    stall = 1'b1;
    tick(3);
    check("p1_drained", 32'(sb.size()), 32'h0);
    check("p1_mem_addr", mem_addr, 32'h10);

    // Back-pressure: FIFO fills at two entries and fetch_pc holds at 8.
    redirect(32'h0);
    out_ready = 1'b0; stall = 1'b0;
    tick(5);
    check("p2_hold_mem_addr", mem_addr, 32'h8);
    check("p2_hold_valid", 32'(out_valid), 32'h1);
    check("p2_hold_head_pc", out_pc, 32'h0);
    expect_out(32'h0); expect_out(32'h4); expect_out(32'h8);
    out_ready = 1'b1;
    tick(1);
    stall = 1'b1;
    tick(3);
    check("p2_drained", 32'(sb.size()), 32'h0);
    check("p2_mem_addr", mem_addr, 32'hC);

    // Redirect flushes buffered pc 4 and 8.
    out_ready = 1'b0;
    redirect(32'h4);
    stall = 1'b0;
    tick(2);
    stall = 1'b1;
    check("p3_buffered_head", out_pc, 32'h4);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    check("p3_redirect_valid_low", 32'(out_valid), 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    expect_out(32'h40);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    tick(3);
    check("p3_drained", 32'(sb.size()), 32'h0);

    // Sequential overrun past the last word faults at 0x100.
    redirect(32'hF8);
    expect_out(32'hF8); expect_out(32'hFC);
    stall = 1'b0;
    tick(2);
    check("p4_no_fault_yet", 32'(fault), 32'h0);
    tick(1);
    check("p4_fault", 32'(fault), 32'h1);
    check("p4_fault_pc", fault_pc, 32'h100);
    tick(4);
    check("p4_fault_valid", 32'(out_valid), 32'h0);
    check("p4_fault_mem_addr", mem_addr, 32'h100);
    check("p4_drained", 32'(sb.size()), 32'h0);
    redirect(32'h20);
    check("p4_fault_cleared", 32'(fault), 32'h0);
    check("p4_fault_pc_held", fault_pc, 32'h100);
    expect_out(32'h20);
    tick(1);
    stall = 1'b1;
    tick(3);
    check("p4_recover_drained", 32'(sb.size()), 32'h0);

    // Misaligned redirect target.
    stall = 1'b0;
    redirect(32'h22);
    check("p5_fault", 32'(fault), 32'h1);
    check("p5_fault_pc", fault_pc, 32'h22);
    check("p5_mem_addr", mem_addr, 32'h22);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("p5_valid_low", 32'(out_valid), 32'h0);
    end

    // Fill the FIFO, then hit it with asynchronous reset between edges.
    out_ready = 1'b0;
    redirect(32'h80);
    check("p6_fault_cleared", 32'(fault), 32'h0);
    check("p6_fault_pc_held", fault_pc, 32'h22);
    tick(3);
    check("p6_full_head", out_pc, 32'h80);
    check("p6_full_mem_addr", mem_addr, 32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check("p6_async_valid", 32'(out_valid), 32'h0);
    check("p6_async_out_pc", out_pc, 32'h0);
    check("p6_async_out_inst", out_inst, 32'h0);
    check("p6_async_mem_addr", mem_addr, 32'h0);
    check("p6_async_fault_pc", fault_pc, 32'h0);
    #2;
    expect_out(32'h0); expect_out(32'h4);
    rst_n = 1'b1; out_ready = 1'b1; stall = 1'b0;
    tick(2);
    stall = 1'b1;
    tick(3);
    check("p6_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
